// File: rtl/mix_columns_ctrl_if.sv
// State exchange bundle between the round controller and the MixColumns sequencer.
// Latency: none (wires only).
// Backpressure: in_ready/out_ready valid-ready handshakes on each side.
interface mix_columns_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_bypass;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    // Sequencer side: consumes input states, produces mixed states.
    modport slave (
        input  in_valid,
        input  in_state,
        input  in_bypass,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_state,
        output busy
    );

    // Round controller side.
    modport master (
        output in_valid,
        output in_state,
        output in_bypass,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_state,
        input  busy
    );
endinterface

// File: rtl/mix_columns_ctrl.sv
// AES MixColumns over a 128-bit state, one shared 32-bit column mixer, one column per clock.
// Latency: 4 cycles from accept to out_valid (mix), result visible right after accept (bypass).
// Backpressure: holds result in DONE until out_ready; accepts nothing outside IDLE.
module mix_columns_ctrl (
    input  logic               clk,
    input  logic               rst_n,
    mix_columns_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MIX  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [127:0] src;
    logic [127:0] dst;
    logic [1:0]   col;
    logic         byp;
    logic [31:0]  mix_in;
    logic [31:0]  mix_out;
    logic         accept;

    // Multiply by x in GF(2^8), reduction polynomial 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // MixWords: one column, row 0 in the most significant byte.
    function automatic logic [31:0] mix_words(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] r0, r1, r2, r3;
        a0 = w[31:24];
        a1 = w[23:16];
        a2 = w[15:8];
        a3 = w[7:0];
        r0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        r1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        r2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        r3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        mix_words = {r0, r1, r2, r3};
    endfunction

    // Column c lives at bit offset (3-c)*32; ~col is 3-col for a 2-bit counter.
    // Select the current source column and run it through the single shared mixer.
    always_comb begin
        mix_in  = src[{~col, 5'd0} +: 32];
        mix_out = mix_words(mix_in);
    end

    assign accept        = (state == IDLE) && bus.in_valid;
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_state = dst;

    // FSM state register; reset aborts any block in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: bypass skips MIX, last column hands over to DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = bus.in_bypass ? DONE : MIX;
                end
            end
            MIX: begin
                if (col == 2'd3) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture on accept, fill one result column per MIX cycle; dst frozen in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src <= '0;
            dst <= '0;
            col <= 2'd0;
            byp <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        src <= bus.in_state;
                        byp <= bus.in_bypass;
                        col <= 2'd0;
                        if (bus.in_bypass) begin
                            dst <= bus.in_state;
                        end
                    end
                end
                MIX: begin
                    dst[{~col, 5'd0} +: 32] <= mix_out;
                    col                     <= col + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // byp is kept for observability of the block mode; it does not steer the datapath after accept.
    logic byp_unused;
    assign byp_unused = byp;

endmodule

// File: doc/mix_columns_ctrl.md
# mix_columns_ctrl

Sequencer that applies the AES MixColumns transform to a full 128-bit state by time-sharing one 32-bit column mixer (one MixWords instance) across the four columns, one column per clock. It sits between ShiftRows and AddRoundKey in the iterative round datapath. It exchanges whole states with the round controller over valid/ready handshakes. A per-block bypass input skips the transform for the final AES round.

## Interface
Parameters: none.

Ports:
- clk  input  1  — sole clock; all state updates on the rising edge.
- rst_n  input  1  — reset, asynchronous, active-low.
- in_valid  input  1  — in_state and in_bypass are valid.
- in_ready  output  1  — block can accept a state.
- in_state  input  128  — state to mix. Column c occupies [127-32c : 96-32c]. The most significant byte of each column is row 0.
- in_bypass  input  1  — 1 = final round: pass in_state through unchanged.
- out_valid  output  1  — out_state holds a completed result.
- out_ready  input  1  — downstream accepts out_state.
- out_state  output  128  — mixed (or bypassed) state; same column layout as in_state.
- busy  output  1  — high in any state other than IDLE.

## Operation
- One MixWords instance internally. Its input comes from a mux over the four columns of the captured input register, selected by a 2-bit column counter col.
- Registers:
  - src (128): captured input.
  - dst (128): result, drives out_state.
  - col (2)
  - byp (1)
  - FSM state
- FSM states: IDLE, MIX, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready, capture src<=in_state, byp<=in_bypass, col<=0.
  - Go to MIX if in_bypass=0.
  - If in_bypass=1, load dst<=in_state and go directly to DONE.
- MIX:
  - Each cycle, write the mixer output for column col into the dst slice for column col, then col<=col+1.
  - After writing column 3 (col==3), go to DONE; col wraps to 0.
  - in_valid is ignored; in_ready=0.
- DONE:
  - out_valid=1; dst is held stable.
  - On out_ready, go to IDLE.
  - No new acceptance in the same cycle; in_ready returns to 1 the following cycle.
- Changes on in_state or in_bypass while not in IDLE have no effect.
- dst slices not yet written during MIX keep their previous contents. Downstream only samples them once out_valid=1.

## Timing
- Reset (rst_n low, asynchronous):
  - FSM=IDLE, col=0, byp=0, src=0, dst=0.
  - Outputs: in_ready=1, out_valid=0, busy=0, out_state=128'h0.
- Reset asserted mid-operation aborts the block immediately; no partial result is ever presented. After release, the block is in IDLE with the same values as above.
- Mix latency: accept edge E0; columns 0..3 written at edges E1..E4; out_valid=1 from E4 onward (4 cycles).
- Bypass latency: accept edge E0; out_valid=1 from E0 onward (1 cycle).
- Throughput: with out_ready held high, mix mode accepts one state every 6 cycles (IDLE, 4×MIX, DONE); bypass mode accepts one every 2 cycles.
- out_valid stays high and out_state stays stable until the out_ready handshake completes. out_ready may be asserted before out_valid with no effect.
- busy=1 in MIX and DONE.
- All arithmetic is inside the shared mixer: GF(2^8) with reduction polynomial 0x11B. The controller performs no arithmetic beyond the 2-bit col increment, which wraps modulo 4.

## Test plan
- FIPS-197 vector:
  - in_state=128'hdb135345_f20a225c_01010101_c6c6c6c6, bypass=0, out_ready=1.
  - Required: out_state=128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6.
  - out_valid rises exactly 4 cycles after acceptance; in_ready=0 throughout.
- Second vector and bypass:
  - in_state=128'hd4d4d4d5_2d26314c_00000000_ffffffff, bypass=0 → out_state=128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff.
  - The same input with bypass=1 → out_state equals in_state, 1 cycle after acceptance.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in DONE, while toggling in_state and asserting in_valid.
  - Required: out_valid and out_state are stable, in_ready=0, no new capture occurs.
  - Release out_ready, then verify a second block processes correctly.
- Reset mid-MIX:
  - Assert rst_n=0 asynchronously (not aligned to a clock edge) when col=2.
  - Required: out_valid=0, out_state=0 and in_ready=1 immediately.
  - After release, the next block produces a correct result.
- Back-to-back stream:
  - Send 8 random states with random bypass flags and random out_ready stalls.
  - Compare every output against a reference MixColumns model.
  - Check ordering, that there are no drops or duplicates, and that each result is accepted exactly once.
